// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB slave register family: ack FSM states,
// word offsets inside the decoded window, counter width and byte-lane merge.
package opb_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_GAP  = 2'd2
  } ack_state_e;

  localparam logic [31:0] WORD_DATA = 32'd0;
  localparam logic [31:0] WORD_AUX  = 32'd1;
  localparam int          CNT_W     = 16;

  // Merge new data into old data per byte lane; be[3] is the most significant
  // byte, which on the big-endian OPB bus is BE[0] / DBus[0:7].
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Address decode and IDLE -> ACK -> GAP handshake for a simple OPB slave.
// accept marks the single edge at which a transfer is taken; xfer_ack is
// registered and high for exactly one cycle afterwards.
module opb_slave_ack_fsm
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01004900,
  parameter logic [31:0] C_HIGHADDR = 32'h010049FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        select,
  input  logic [31:0] addr,
  output logic        accept,
  output logic        xfer_ack,
  output logic [31:0] word
);

  ack_state_e state;
  logic       hit;

  assign hit    = select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign accept = !rst && (state == ST_IDLE) && hit;
  assign word   = (addr - C_BASEADDR) >> 2;

  // Handshake sequencer; GAP ignores select so acks are never back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      xfer_ack <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          xfer_ack <= hit;
          state    <= hit ? ST_ACK : ST_IDLE;
        end
        ST_ACK: begin
          xfer_ack <= 1'b0;
          state    <= ST_GAP;
        end
        default: begin
          xfer_ack <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/opb_register_ppc2simulink_sc.sv
// OPB-writable register exported to fabric (PPC -> Simulink direction).
// Word 0 is the data register; word 1 is the optional write counter enabled
// by macro OPB_P2S_WRCOUNT_EN (reads 0 and ignores writes when undefined).
module opb_register_ppc2simulink_sc
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h01004900,
  parameter logic [31:0] C_HIGHADDR    = 32'h010049FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter string       C_FAMILY      = "virtex5",
  parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [31:0]             user_data_out,
  output logic                    user_data_valid
);

  localparam bit unused_family = (C_FAMILY != "");

  logic        accept, rd_hit, wr_data, wr_aux;
  logic [31:0] word, data_q, aux_v, rd_v, dbus_v;
  logic [3:0]  be_v;
  logic        unused_ok;

  // Bus bit 0 is the MSB, so plain assignment maps OPB bit 0 to user bit 31.
  assign dbus_v    = OPB_DBus;
  assign be_v      = OPB_BE;
  assign unused_ok = &{1'b1, OPB_seqAddr};

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_fsm (
    .clk      (OPB_Clk),
    .rst      (OPB_Rst),
    .select   (OPB_select),
    .addr     (OPB_ABus),
    .accept   (accept),
    .xfer_ack (Sl_xferAck),
    .word     (word)
  );

  assign rd_hit  = accept && OPB_RNW;
  assign wr_data = accept && !OPB_RNW && (word == WORD_DATA);
  assign wr_aux  = accept && !OPB_RNW && (word == WORD_AUX);

  // Data register commits at the edge entering ACK so the new value and the
  // valid pulse appear together in the ACK cycle.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      data_q          <= C_RESET_VALUE;
      user_data_valid <= 1'b0;
    end else begin
      user_data_valid <= wr_data;
      if (wr_data) data_q <= be_merge(data_q, dbus_v, be_v);
    end
  end

`ifdef OPB_P2S_WRCOUNT_EN
  logic [CNT_W-1:0] wr_count;

  // Counts word-0 commits, wraps naturally; any word-1 write clears it.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst)      wr_count <= '0;
    else if (wr_aux)  wr_count <= '0;
    else if (wr_data) wr_count <= wr_count + 1'b1;
  end

  assign aux_v = {{(32-CNT_W){1'b0}}, wr_count};
`else
  assign aux_v = {31'b0, wr_aux & 1'b0};
`endif

  assign rd_v = (word == WORD_DATA) ? data_q :
                (word == WORD_AUX)  ? aux_v  : 32'h0;

  // Read data is registered and only non-zero in the ACK cycle (OR-bus).
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst)     Sl_DBus <= '0;
    else if (rd_hit) Sl_DBus <= rd_v;
    else             Sl_DBus <= '0;
  end

  assign Sl_errAck     = 1'b0;
  assign Sl_retry      = 1'b0;
  assign Sl_toutSup    = 1'b0;
  assign user_data_out = data_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink_sc.sv
// Self-checking bench for opb_register_ppc2simulink_sc: transaction-level
// reference model compared every cycle, plus directed literal scenarios.
// The counter scenario runs only when OPB_P2S_WRCOUNT_EN is defined.
module tb_opb_register_ppc2simulink_sc;
  localparam logic [31:0] BASE = 32'h01004900;
  localparam logic [31:0] HIGH = 32'h010049FF;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst;
  logic [0:31] OPB_ABus, OPB_DBus;
  logic [0:3]  OPB_BE;
  logic        OPB_RNW, OPB_select, OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [31:0] user_data_out;
  logic        user_data_valid;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  opb_register_ppc2simulink_sc dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_out(user_data_out), .user_data_valid(user_data_valid)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is accepted when idle and the address is in
  // the window; afterwards two edges (ack, gap) are blocked.
  logic [31:0] m_data = 32'h0;
  logic [15:0] m_cnt  = 16'h0;
  int          m_busy = 0;
  logic        e_ack = 1'b0, e_valid = 1'b0;
  logic [31:0] e_dbus = 32'h0;

  always @(posedge OPB_Clk) begin
    logic [31:0] a, dv, w;
    a  = OPB_ABus;
    dv = OPB_DBus;
    if (OPB_Rst) begin
      m_data = 32'h0; m_cnt = 16'h0; m_busy = 0;
      e_ack = 1'b0; e_valid = 1'b0; e_dbus = 32'h0;
    end else begin
      e_ack = 1'b0; e_valid = 1'b0; e_dbus = 32'h0;
      if (m_busy > 0) m_busy--;
      else if (OPB_select && a >= BASE && a <= HIGH) begin
        m_busy = 2;
        e_ack  = 1'b1;
        w = (a - BASE) / 4;
        if (OPB_RNW) begin
          if (w == 0) e_dbus = m_data;
`ifdef OPB_P2S_WRCOUNT_EN
          else if (w == 1) e_dbus = {16'h0, m_cnt};
`endif
        end else if (w == 0) begin
          for (int k = 0; k < 4; k++)
            if (OPB_BE[k]) m_data[31-8*k -: 8] = dv[31-8*k -: 8];
          e_valid = 1'b1;
          m_cnt   = m_cnt + 16'h1;
        end else if (w == 1) m_cnt = 16'h0;
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge OPB_Clk) begin
    if (chk_en) begin
      check("xferAck", {31'b0, Sl_xferAck}, {31'b0, e_ack});
      check("Sl_DBus", Sl_DBus, e_dbus);
      check("user_data_out", user_data_out, m_data);
      check("user_data_valid", {31'b0, user_data_valid}, {31'b0, e_valid});
      check("tied_zero", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);
    end
  end

  // One transfer from IDLE; captures the ACK-cycle outputs, returns in IDLE.
  task automatic xfer(input logic rnw, input logic [31:0] a, input logic [0:3] be,
                      input logic [31:0] d, output logic ack, output logic [31:0] dbus,
                      output logic [31:0] ud, output logic vld);
    OPB_select = 1'b1; OPB_RNW = rnw; OPB_ABus = a; OPB_BE = be; OPB_DBus = d;
    @(posedge OPB_Clk); #1;
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    ack = Sl_xferAck; dbus = Sl_DBus; ud = user_data_out; vld = user_data_valid;
    @(posedge OPB_Clk); @(posedge OPB_Clk); #1;
  endtask

  logic        r_ack, r_vld;
  logic [31:0] r_dbus, r_ud;
  logic [5:0]  pat;
  int          nack;

  initial begin
    OPB_Rst = 1'b1; OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_seqAddr = 1'b0;
    OPB_ABus = 32'h0; OPB_DBus = 32'h0; OPB_BE = 4'h0;
    @(posedge OPB_Clk); chk_en = 1'b1;
    @(posedge OPB_Clk); #1; OPB_Rst = 1'b0;
    @(negedge OPB_Clk);
    check("rst_ack", {31'b0, Sl_xferAck}, 32'h0);
    check("rst_dbus", Sl_DBus, 32'h0);
    check("rst_data", user_data_out, 32'h0);
    check("rst_valid", {31'b0, user_data_valid}, 32'h0);
    @(posedge OPB_Clk); #1;

    // Full-word write: ack, new value and valid pulse in the same cycle.
    xfer(1'b0, BASE, 4'b1111, 32'hDEADBEEF, r_ack, r_dbus, r_ud, r_vld);
    check("w0_ack", {31'b0, r_ack}, 32'h1);
    check("w0_data", r_ud, 32'hDEADBEEF);
    check("w0_valid", {31'b0, r_vld}, 32'h1);

    // Byte-enable merge then readback.
    xfer(1'b0, BASE, 4'b1111, 32'h11223344, r_ack, r_dbus, r_ud, r_vld);
    check("w1_data", r_ud, 32'h11223344);
    xfer(1'b0, BASE, 4'b0101, 32'hAABBCCDD, r_ack, r_dbus, r_ud, r_vld);
    check("be_data", r_ud, 32'h11BB33DD);
    check("be_valid", {31'b0, r_vld}, 32'h1);
    xfer(1'b1, BASE, 4'b1111, 32'h0, r_ack, r_dbus, r_ud, r_vld);
    check("rd_dbus", r_dbus, 32'h11BB33DD);
    check("rd_valid", {31'b0, r_vld}, 32'h0);
    @(negedge OPB_Clk);
    check("rd_idle_dbus", Sl_DBus, 32'h0);
    @(posedge OPB_Clk); #1;

    // Select held for six cycles: acks at cycles 2 and 5 only.
    OPB_select = 1'b1; OPB_RNW = 1'b1; OPB_ABus = BASE;
    pat = 6'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge OPB_Clk); pat = {pat[4:0], Sl_xferAck};
      @(posedge OPB_Clk);
    end
    #1; OPB_select = 1'b0;
    check("ack_spacing", {26'b0, pat}, 32'h12);

    // Out-of-window select: never acked, register untouched.
    OPB_select = 1'b1; OPB_RNW = 1'b0; OPB_ABus = 32'h01004A00;
    OPB_BE = 4'b1111; OPB_DBus = 32'hCAFEF00D;
    nack = 0;
    repeat (10) begin
      @(negedge OPB_Clk); if (Sl_xferAck) nack++;
      @(posedge OPB_Clk);
    end
    #1; OPB_select = 1'b0;
    check("oow_acks", nack, 0);
    check("oow_data", user_data_out, 32'h11BB33DD);

    // Higher window word: acked, reads zero, writes ignored.
    xfer(1'b0, BASE + 32'h8, 4'b1111, 32'hFFFFFFFF, r_ack, r_dbus, r_ud, r_vld);
    check("w2_wr_ack", {31'b0, r_ack}, 32'h1);
    check("w2_wr_data", r_ud, 32'h11BB33DD);
    check("w2_wr_valid", {31'b0, r_vld}, 32'h0);
    xfer(1'b1, BASE + 32'h8, 4'b1111, 32'h0, r_ack, r_dbus, r_ud, r_vld);
    check("w2_rd_dbus", r_dbus, 32'h0);
`ifndef OPB_P2S_WRCOUNT_EN
    xfer(1'b1, BASE + 32'h4, 4'b1111, 32'h0, r_ack, r_dbus, r_ud, r_vld);
    check("w1_rd_ack", {31'b0, r_ack}, 32'h1);
    check("w1_rd_dbus", r_dbus, 32'h0);
`endif

    // Reset during the ACK of a write; then a hit right after deassertion.
    OPB_select = 1'b1; OPB_RNW = 1'b0; OPB_ABus = BASE; OPB_BE = 4'b1111;
    OPB_DBus = 32'h5;
    @(posedge OPB_Clk); #1;
    OPB_Rst = 1'b1; OPB_select = 1'b0;
    @(posedge OPB_Clk); #1;
    OPB_Rst = 1'b0; OPB_select = 1'b1; OPB_DBus = 32'h77;
    @(negedge OPB_Clk);
    check("rstack_data", user_data_out, 32'h0);
    check("rstack_ack", {31'b0, Sl_xferAck}, 32'h0);
    check("rstack_valid", {31'b0, user_data_valid}, 32'h0);
    @(posedge OPB_Clk); #1; OPB_select = 1'b0;
    @(negedge OPB_Clk);
    check("post_rst_ack", {31'b0, Sl_xferAck}, 32'h1);
    check("post_rst_data", user_data_out, 32'h77);
    @(posedge OPB_Clk); @(posedge OPB_Clk); #1;

    // Randomized traffic, checked by the every-cycle compare.
    repeat (1500) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0: a = BASE + 32'($urandom_range(0, 3));
        1: a = BASE + 32'h4 + 32'($urandom_range(0, 3));
        2: a = BASE + 32'($urandom_range(8, 255));
        3: a = HIGH - 32'($urandom_range(0, 3));
        4: a = BASE - 32'($urandom_range(1, 16));
        default: a = HIGH + 32'($urandom_range(1, 16));
      endcase
      OPB_Rst     = ($urandom_range(0, 63) == 0);
      OPB_select  = 1'($urandom_range(0, 1));
      OPB_RNW     = 1'($urandom_range(0, 1));
      OPB_seqAddr = 1'($urandom_range(0, 1));
      OPB_BE      = 4'($urandom);
      OPB_DBus    = $urandom;
      OPB_ABus    = a;
      @(posedge OPB_Clk); #1;
    end
    OPB_Rst = 1'b0; OPB_select = 1'b0;
    repeat (3) @(posedge OPB_Clk); #1;

`ifdef OPB_P2S_WRCOUNT_EN
    xfer(1'b0, BASE + 32'h4, 4'b1111, 32'h0, r_ack, r_dbus, r_ud, r_vld);
    repeat (65537) xfer(1'b0, BASE, 4'b0000, 32'h0, r_ack, r_dbus, r_ud, r_vld);
    xfer(1'b1, BASE + 32'h4, 4'b1111, 32'h0, r_ack, r_dbus, r_ud, r_vld);
    check("cnt_wrap", r_dbus, 32'h1);
    xfer(1'b0, BASE + 32'h4, 4'b1111, 32'h0, r_ack, r_dbus, r_ud, r_vld);
    xfer(1'b1, BASE + 32'h4, 4'b1111, 32'h0, r_ack, r_dbus, r_ud, r_vld);
    check("cnt_clear", r_dbus, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/opb_register_ppc2simulink_sc.md
OPB_REGISTER_PPC2SIMULINK_SC -- requirements
Module: opb_register_ppc2simulink_sc

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01004900, first byte address of the decoded window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h010049FF, last byte address of the decoded window.
REQ-003 SHALL have parameters C_OPB_AWIDTH and C_OPB_DWIDTH, both default 32, giving the OPB address and data widths.
REQ-004 SHALL have parameter C_FAMILY, default "virtex5", giving the target family (informational).
REQ-005 SHALL have parameter C_RESET_VALUE, default 32'h0, giving the user register reset value.
REQ-006 SHALL use a single clock and a synchronous, active-high reset, with ports OPB_Clk and OPB_Rst.
REQ-007 SHALL provide these ports (name, direction, width, meaning):
 OPB_Clk  in  1  sole clock
 OPB_Rst  in  1  synchronous active-high reset
 OPB_ABus  in  [0:31]  byte address
 OPB_BE  in  [0:3]  byte enables; BE[0] qualifies DBus[0:7]
 OPB_DBus  in  [0:31]  write data
 OPB_RNW  in  1  1=read, 0=write
 OPB_select  in  1  transfer request
 OPB_seqAddr  in  1  sequential hint (ignored)
 Sl_DBus  out  [0:31]  read data; zero when not acking
 Sl_xferAck  out  1  one-cycle transfer acknowledge
 Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
 user_data_out  out  [31:0]  register value to fabric; user bit 31 = OPB bit 0
 user_data_valid  out  1  one-cycle pulse on each commit to word 0

Function
REQ-008 SHALL decode a hit as OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word offset = ABus[29] (0 = data, 1 = aux); higher window words read 0, ignore writes, and are still acked.
REQ-009 SHALL run FSM IDLE -> ACK -> GAP -> IDLE: IDLE moves to ACK on a hit; ACK lasts exactly one cycle; GAP lasts exactly one cycle, ignores select, and returns to IDLE.
REQ-010 SHALL assert Sl_xferAck only in ACK, giving latency of 1 cycle from the hit sample to ack, with no back-to-back acks.
REQ-011 SHALL, on a write hit, update each byte of the data register whose BE is 1 at the edge that enters ACK; bytes with BE=0 are unchanged; BE=0000 changes nothing but still acks.
REQ-012 SHALL pulse user_data_valid in the ACK cycle of every word-0 write, regardless of BE; user_data_out equals the new value in that same cycle.
REQ-013 SHALL drive Sl_DBus with read data only in ACK on a read hit, and drive all zeros otherwise (OR-bus).
REQ-014 SHALL ignore select with an out-of-window address: no ack, no state change.
REQ-015 SHALL, if OPB_select drops while in ACK, still complete ACK and GAP (the abort is harmless).

Reset
REQ-016 SHALL, while OPB_Rst=1 at an edge, apply: FSM=IDLE, user_data_out=C_RESET_VALUE, user_data_valid=0, Sl_xferAck=0, Sl_DBus=0, counter=0.
REQ-017 SHALL, if reset is asserted in ACK or GAP, abort the transfer with no further ack and no commit; the first hit is accepted in the cycle after reset deasserts.

Configuration
REQ-018 SHALL, when macro OPB_P2S_WRCOUNT_EN is defined, include a 16-bit counter of word-0 writes that wraps 0xFFFF->0x0000, reads at word 1 as {16'h0, count}, and clears on any write to word 1.
REQ-019 SHALL, when OPB_P2S_WRCOUNT_EN is undefined, omit the counter; word 1 then reads 0 and ignores writes.

Structure
REQ-020 SHALL place the FSM state enum, the word-offset constants and the counter width in shared package opb_reg_pkg.
REQ-021 SHALL factor the decode/ack FSM into sub-module opb_slave_ack_fsm, which is reusable by the simulink2ppc register.

Verification
REQ-022 SHALL verify a write of 0xDEADBEEF to 0x01004900 with BE=1111: xferAck 1 cycle later, user_data_out=0xDEADBEEF and valid=1 in the same cycle.
REQ-023 SHALL verify that, after register=0x11223344, a write of 0xAABBCCDD with BE=0101 gives 0x11BB33DD, then a read at 0x01004900 returns 0x11BB33DD with Sl_DBus=0 outside ACK.
REQ-024 SHALL verify that select held high continuously for 6 cycles produces acks only in cycles 2 and 5 (IDLE/ACK/GAP spacing).
REQ-025 SHALL verify that select with address 0x01004A00 produces no ack within 10 cycles and leaves the register unchanged.
REQ-026 SHALL verify that OPB_Rst asserted in the ACK cycle of a write of 0x5 gives no commit, and the register and outputs return to reset values.
REQ-027 SHALL verify, with OPB_P2S_WRCOUNT_EN defined, that 65537 word-0 writes give a word-1 read of 0x00000001, and a word-1 write then a read gives 0.
